// File: rtl/gsim_engine.sv
// Gauss-Seidel solver: streams A/b per matrix from memory, runs ITER sweeps on one MAC, writes x.
// Optional GSIM_EARLY_EXIT_EN: ends a matrix early once a sweep changes no x_i by more than TOL.
module gsim_engine #(
  parameter int unsigned N       = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned XW      = 32,
  parameter int unsigned ITER    = 16,
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned MAX_MTX = 16
`ifdef GSIM_EARLY_EXIT_EN
  , parameter logic [31:0] TOL   = 32'h0000_0010
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_module_en,
  input  logic [4:0]        i_matrix_num,
  output logic              o_proc_done,
  output logic              o_mem_rreq,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic [N*AW-1:0]   i_mem_dout,
  input  logic              i_mem_dout_vld,
  output logic              o_x_wen,
  output logic [8:0]        o_x_addr,
  output logic [XW-1:0]     o_x_data
`ifdef GSIM_EARLY_EXIT_EN
  , output logic            o_early_exit
`endif
);

  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW   = $clog2(N + 1);
  localparam int unsigned SW   = $clog2(ITER + 1);
  localparam int unsigned ACCW = XW + AW + 4;
  localparam int unsigned PW   = ACCW + AW;
  localparam logic signed [XW-1:0] XMax = {1'b0, {(XW-1){1'b1}}};
  localparam logic signed [XW-1:0] XMin = {1'b1, {(XW-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StUpd, StWrite, StNext, StDone} state_e;

  state_e                   state_q;
  logic signed [AW-1:0]     a_q [N][N];
  logic signed [AW-1:0]     b_q [N];
  logic signed [XW-1:0]     x_q [N];
  logic signed [ACCW-1:0]   acc_q;
  logic signed [AW-1:0]     r_q;
  logic [IW-1:0]            row_q, col_q, widx_q;
  logic [CW-1:0]            req_cnt_q, rd_cnt_q;
  logic [SW-1:0]            sweep_q;
  logic [4:0]               mtx_q, num_q;
  logic [MEM_AW-1:0]        mbase_q;
  logic [8:0]               xbase_q;

  logic [4:0]               num_clamped;
  logic [IW-1:0]            row_nxt;
  logic signed [AW+XW-1:0]  term;
  logic signed [PW-1:0]     prod, prod_sh;
  logic signed [XW-1:0]     upd_sat;

  always_comb begin
    num_clamped = (i_matrix_num > 5'(MAX_MTX)) ? 5'(MAX_MTX) : i_matrix_num;
    row_nxt     = (row_q == IW'(N - 1)) ? '0 : row_q + IW'(1);
    term        = (AW+XW)'(a_q[row_q][col_q]) * (AW+XW)'(x_q[col_q]);
    prod        = PW'(acc_q) * PW'(r_q);
    prod_sh     = prod >>> 15;
    if (prod_sh > PW'(XMax))      upd_sat = XMax;
    else if (prod_sh < PW'(XMin)) upd_sat = XMin;
    else                          upd_sat = prod_sh[XW-1:0];
  end

`ifdef GSIM_EARLY_EXIT_EN
  logic [XW:0] max_q, diff, adiff, sweep_max;
  always_comb begin
    diff      = {upd_sat[XW-1], upd_sat} - {x_q[row_q][XW-1], x_q[row_q]};
    adiff     = diff[XW] ? -diff : diff;
    sweep_max = (adiff > max_q) ? adiff : max_q;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      o_proc_done <= 1'b0;
      o_mem_rreq  <= 1'b0;
      o_mem_addr  <= '0;
      o_x_wen     <= 1'b0;
      o_x_addr    <= '0;
      o_x_data    <= '0;
      acc_q       <= '0;
      r_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      widx_q      <= '0;
      req_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      sweep_q     <= '0;
      mtx_q       <= '0;
      num_q       <= '0;
      mbase_q     <= '0;
      xbase_q     <= '0;
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
        for (int j = 0; j < N; j++) a_q[i][j] <= '0;
      end
`ifdef GSIM_EARLY_EXIT_EN
      max_q        <= '0;
      o_early_exit <= 1'b0;
`endif
    end else begin
      o_proc_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_module_en) begin
            num_q   <= num_clamped;
            mtx_q   <= '0;
            mbase_q <= '0;
            xbase_q <= '0;
            if (num_clamped == '0) begin
              state_q     <= StDone;
              o_proc_done <= 1'b1;
            end else begin
              state_q    <= StLoad;
              o_mem_rreq <= 1'b1;
              o_mem_addr <= '0;
              req_cnt_q  <= '0;
              rd_cnt_q   <= '0;
              for (int i = 0; i < N; i++) x_q[i] <= '0;
            end
          end
        end
        StLoad: begin
          if (o_mem_rreq && i_mem_rrdy) begin
            if (req_cnt_q == CW'(N)) begin
              o_mem_rreq <= 1'b0;
              o_mem_addr <= '0;
            end else begin
              o_mem_addr <= o_mem_addr + MEM_AW'(1);
              req_cnt_q  <= req_cnt_q + CW'(1);
            end
          end
          if (i_mem_dout_vld) begin
            for (int k = 0; k < N; k++) begin
              if (rd_cnt_q == '0) b_q[k] <= i_mem_dout[k*AW +: AW];
              else                a_q[IW'(rd_cnt_q - CW'(1))][k] <= i_mem_dout[k*AW +: AW];
            end
            if (rd_cnt_q == CW'(N)) begin
              state_q <= StMac;
              row_q   <= '0;
              col_q   <= '0;
              sweep_q <= '0;
              acc_q   <= ACCW'(b_q[0]) <<< 16;
`ifdef GSIM_EARLY_EXIT_EN
              max_q   <= '0;
`endif
            end else begin
              rd_cnt_q <= rd_cnt_q + CW'(1);
            end
          end
        end
        StMac: begin
          // Diagonal slot carries the reciprocal, not a coefficient to accumulate.
          if (col_q == row_q) r_q <= a_q[row_q][col_q];
          else                acc_q <= acc_q - ACCW'(term);
          if (col_q == IW'(N - 1)) state_q <= StUpd;
          else                     col_q <= col_q + IW'(1);
        end
        StUpd: begin
          x_q[row_q] <= upd_sat;
          col_q      <= '0;
          row_q      <= row_nxt;
          acc_q      <= ACCW'(b_q[row_nxt]) <<< 16;
          if (row_q == IW'(N - 1)) begin
            sweep_q <= sweep_q + SW'(1);
`ifdef GSIM_EARLY_EXIT_EN
            max_q   <= '0;
`endif
            if (sweep_q == SW'(ITER - 1)) begin
              state_q  <= StWrite;
              o_x_wen  <= 1'b1;
              o_x_addr <= xbase_q;
              o_x_data <= x_q[0];
              widx_q   <= '0;
            end
`ifdef GSIM_EARLY_EXIT_EN
            else if (sweep_q != '0 && sweep_max <= (XW+1)'(TOL)) begin
              state_q      <= StWrite;
              o_x_wen      <= 1'b1;
              o_x_addr     <= xbase_q;
              o_x_data     <= x_q[0];
              widx_q       <= '0;
              o_early_exit <= 1'b1;
            end
`endif
            else begin
              state_q <= StMac;
            end
          end else begin
            state_q <= StMac;
`ifdef GSIM_EARLY_EXIT_EN
            max_q   <= sweep_max;
`endif
          end
        end
        StWrite: begin
          if (widx_q == IW'(N - 1)) begin
            state_q  <= StNext;
            o_x_wen  <= 1'b0;
            o_x_addr <= '0;
            o_x_data <= '0;
`ifdef GSIM_EARLY_EXIT_EN
            o_early_exit <= 1'b0;
`endif
          end else begin
            widx_q   <= widx_q + IW'(1);
            o_x_addr <= o_x_addr + 9'(1);
            o_x_data <= x_q[widx_q + IW'(1)];
          end
        end
        StNext: begin
          mtx_q <= mtx_q + 5'(1);
          if (mtx_q + 5'(1) == num_q) begin
            state_q     <= StDone;
            o_proc_done <= 1'b1;
          end else begin
            state_q    <= StLoad;
            mbase_q    <= mbase_q + MEM_AW'(N + 1);
            xbase_q    <= xbase_q + 9'(N);
            o_mem_rreq <= 1'b1;
            o_mem_addr <= mbase_q + MEM_AW'(N + 1);
            req_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            for (int i = 0; i < N; i++) x_q[i] <= '0;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_engine.sv
// Randomized bench for gsim_engine (N=4) against a wide-integer Gauss-Seidel reference model.
module tb_gsim_engine;
  localparam int N = 4, AW = 16, XW = 32, ITER = 16, MEM_AW = 10, MAX_MTX = 16;
  localparam logic signed [127:0] SatMax = 128'sd2147483647;
  localparam logic signed [127:0] SatMin = -128'sd2147483648;

  logic              i_clk, i_reset_n, i_module_en;
  logic [4:0]        i_matrix_num;
  logic              o_proc_done, o_mem_rreq, i_mem_rrdy, i_mem_dout_vld, o_x_wen;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [N*AW-1:0]   i_mem_dout;
  logic [8:0]        o_x_addr;
  logic [XW-1:0]     o_x_data;
`ifdef GSIM_EARLY_EXIT_EN
  logic              o_early_exit;
  int                early_seen;
`endif

  gsim_engine #(.N(N), .AW(AW), .XW(XW), .ITER(ITER), .MEM_AW(MEM_AW), .MAX_MTX(MAX_MTX)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_module_en(i_module_en), .i_matrix_num(i_matrix_num),
    .o_proc_done(o_proc_done), .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr),
    .i_mem_rrdy(i_mem_rrdy), .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
    .o_x_wen(o_x_wen), .o_x_addr(o_x_addr), .o_x_data(o_x_data)
`ifdef GSIM_EARLY_EXIT_EN
    , .o_early_exit(o_early_exit)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [N*AW-1:0] mem [0:1023];
  logic [XW-1:0]   exp_x [MAX_MTX*N];
  int              acc_addr_q[$], resp_addr_q[$], resp_due_q[$], wr_addr_q[$];
  logic [XW-1:0]   wr_data_q[$];
  int              n_checks, n_fail, done_cnt, cyc, last_due, rrdy_mode;
  logic            rrdy_tog;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder and output monitor, all on the falling edge.
  initial begin
    int due;
    i_mem_rrdy = 1'b0; i_mem_dout_vld = 1'b0; i_mem_dout = '0;
    cyc = 0; last_due = 0; rrdy_tog = 1'b0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (o_x_wen) begin
        wr_addr_q.push_back(int'(o_x_addr));
        wr_data_q.push_back(o_x_data);
`ifdef GSIM_EARLY_EXIT_EN
        if (o_early_exit) early_seen = 1;
`endif
      end
      if (o_proc_done) done_cnt++;
      if (!i_reset_n) begin
        resp_addr_q.delete(); resp_due_q.delete();
        i_mem_rrdy = 1'b0; i_mem_dout_vld = 1'b0;
        continue;
      end
      if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
        i_mem_dout_vld = 1'b1;
        i_mem_dout     = mem[resp_addr_q[0]];
        void'(resp_addr_q.pop_front()); void'(resp_due_q.pop_front());
      end else begin
        i_mem_dout_vld = 1'b0;
        i_mem_dout     = (N*AW)'({$urandom(), $urandom()});
      end
      rrdy_tog = ~rrdy_tog;
      if (rrdy_mode == 0)      i_mem_rrdy = 1'b1;
      else if (rrdy_mode == 1) i_mem_rrdy = rrdy_tog;
      else                     i_mem_rrdy = 1'($urandom_range(0, 1));
      if (o_mem_rreq && i_mem_rrdy) begin
        acc_addr_q.push_back(int'(o_mem_addr));
        due = cyc + 2 + ((rrdy_mode != 0) ? int'($urandom_range(0, 2)) : 0);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_addr_q.push_back(int'(o_mem_addr));
        resp_due_q.push_back(due);
      end
    end
  end

  // kind 0: 4*I with fixed b; 1: random diagonally dominant; 2: saturating system.
  task automatic set_matrix(input int m, input int kind);
    int base, bv, aii, v;
    logic [N*AW-1:0] w;
    base = m * (N + 1);
    for (int k = 0; k < N; k++) begin
      if (kind == 0)      bv = (k == 0) ? 4 : (k == 1) ? 8 : (k == 2) ? -4 : 0;
      else if (kind == 1) bv = int'($urandom_range(0, 2000)) - 1000;
      else                bv = 32'h7FFF;
      w[k*AW +: AW] = AW'(bv);
    end
    mem[base] = w;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == i) begin
          aii = int'($urandom_range(8, 40));
          v = (kind == 0) ? 32'h2000 : (kind == 1) ? (32768 + aii / 2) / aii : 32'h7FFF;
        end else begin
          v = (kind == 0) ? 0 : (kind == 1) ? ($urandom_range(0, 1) ? 1 : -1) : -32767;
        end
        w[j*AW +: AW] = AW'(v);
      end
      mem[base + 1 + i] = w;
    end
  endtask

  task automatic run_model(input int m);
    logic signed [127:0] x [N];
    logic signed [127:0] acc, p, coef, d, maxd;
    logic [N*AW-1:0] bw, w;
    int base;
    base = m * (N + 1);
    bw = mem[base];
    for (int k = 0; k < N; k++) x[k] = '0;
    for (int s = 0; s < ITER; s++) begin
      maxd = '0;
      for (int i = 0; i < N; i++) begin
        w = mem[base + 1 + i];
        acc = $signed(bw[i*AW +: AW]);
        acc = acc * 65536;
        for (int j = 0; j < N; j++) begin
          if (j != i) begin
            coef = $signed(w[j*AW +: AW]);
            acc = acc - coef * x[j];
          end
        end
        coef = $signed(w[i*AW +: AW]);
        p = (acc * coef) >>> 15;
        if (p > SatMax) p = SatMax;
        else if (p < SatMin) p = SatMin;
        d = (p > x[i]) ? p - x[i] : x[i] - p;
        if (d > maxd) maxd = d;
        x[i] = p;
      end
`ifdef GSIM_EARLY_EXIT_EN
      if (s >= 1 && maxd <= 16) break;
`endif
    end
    for (int i = 0; i < N; i++) exp_x[m*N + i] = x[i][XW-1:0];
  endtask

  task automatic clear_mon();
    acc_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_job(input int num, input int mode, input int limit);
    int nm, k;
    nm = (num > MAX_MTX) ? MAX_MTX : num;
    for (int m = 0; m < nm; m++) run_model(m);
    #1;
    clear_mon();
    rrdy_mode = mode;
    @(negedge i_clk);
    i_matrix_num = 5'(num);
    i_module_en  = 1'b1;
    @(negedge i_clk);
    i_module_en  = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge i_clk);
      k++;
    end
    repeat (3) @(negedge i_clk);
    #1;
    check_eq("done_pulses", 64'(done_cnt), 64'(1));
    check_eq("wr_count", 64'(wr_addr_q.size()), 64'(nm * N));
    for (int w = 0; w < wr_addr_q.size() && w < nm * N; w++) begin
      check_eq("wr_addr", 64'(wr_addr_q[w]), 64'(w));
      check_eq("wr_data", 64'(wr_data_q[w]), 64'(exp_x[w]));
    end
    check_eq("rd_count", 64'(acc_addr_q.size()), 64'(nm * (N + 1)));
    for (int r = 0; r < acc_addr_q.size() && r < nm * (N + 1); r++)
      check_eq("rd_addr", 64'(acc_addr_q[r]), 64'(r));
  endtask

  initial begin
    int k;
    n_checks = 0; n_fail = 0; done_cnt = 0; rrdy_mode = 0;
`ifdef GSIM_EARLY_EXIT_EN
    early_seen = 0;
`endif
    i_reset_n = 1'b0; i_module_en = 1'b0; i_matrix_num = '0;
    repeat (3) @(negedge i_clk);
    #1;
    check_eq("reset_outputs",
             64'({o_proc_done, o_mem_rreq, o_mem_addr, o_x_wen, o_x_addr, o_x_data}), 64'(0));
    @(negedge i_clk);
    i_reset_n = 1'b1;

    set_matrix(0, 0);
    run_job(1, 0, 2000);
    if (wr_data_q.size() == 4) begin
      check_eq("diag_x0", 64'(wr_data_q[0]), 64'(32'h0001_0000));
      check_eq("diag_x1", 64'(wr_data_q[1]), 64'(32'h0002_0000));
      check_eq("diag_x2", 64'(wr_data_q[2]), 64'(32'hFFFF_0000));
      check_eq("diag_x3", 64'(wr_data_q[3]), 64'(32'h0000_0000));
    end
`ifdef GSIM_EARLY_EXIT_EN
    check_eq("early_exit", 64'(early_seen), 64'(1));
`endif

    run_job(1, 1, 2000);

    for (int m = 0; m < 3; m++) set_matrix(m, 1);
    run_job(3, 2, 6000);

    // Zero matrices: done on the very next cycle, no memory traffic.
    #1;
    clear_mon();
    @(negedge i_clk);
    i_matrix_num = 5'd0;
    i_module_en  = 1'b1;
    @(negedge i_clk);
    i_module_en  = 1'b0;
    #1;
    check_eq("zero_done_t1", 64'(o_proc_done), 64'(1));
    @(negedge i_clk);
    #1;
    check_eq("zero_done_t2", 64'(o_proc_done), 64'(0));
    repeat (3) @(negedge i_clk);
    #1;
    check_eq("zero_no_rreq", 64'(acc_addr_q.size()), 64'(0));
    check_eq("zero_done_cnt", 64'(done_cnt), 64'(1));

    for (int m = 0; m < MAX_MTX; m++) set_matrix(m, 1);
    run_job(20, 2, 30000);

    set_matrix(0, 2);
    run_job(1, 0, 2000);
    if (wr_data_q.size() == 4) check_eq("sat_x0", 64'(wr_data_q[0]), 64'(32'h7FFF_FFFF));

    // Reset in the middle of MAC, then restart.
    set_matrix(0, 1);
    #1;
    clear_mon();
    rrdy_mode = 0;
    @(negedge i_clk);
    i_matrix_num = 5'd1;
    i_module_en  = 1'b1;
    @(negedge i_clk);
    i_module_en  = 1'b0;
    k = 0;
    while (acc_addr_q.size() < N + 1 && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    repeat (40) @(negedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_eq("midrst_outputs",
             64'({o_proc_done, o_mem_rreq, o_mem_addr, o_x_wen, o_x_addr, o_x_data}), 64'(0));
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (400) @(negedge i_clk);
    #1;
    check_eq("midrst_no_done", 64'(done_cnt), 64'(0));
    check_eq("midrst_no_wr", 64'(wr_addr_q.size()), 64'(0));
    run_job(1, 2, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gsim_engine.md
Name: gsim_engine

Overview:
- Parametrised Gauss-Seidel solver for A·x = b, with configurable dimension N, coefficient and solution widths, and iteration count.
- Streams each matrix from the shared matrix memory into local register arrays.
- Runs ITER Gauss-Seidel sweeps on one sequential MAC, then writes x to the result memory.
- Sits between the matrix memory port and the result write port; processes i_matrix_num matrices per start and pulses o_proc_done when finished.

Parameters:
- N, 16, matrix dimension (2..16); one memory word holds N coefficients.
- AW, 16, coefficient / b element width, signed integer.
- XW, 32, solution width, signed Q16.16.
- ITER, 16, Gauss-Seidel sweeps per matrix.
- MEM_AW, 10, matrix memory address width.
- MAX_MTX, 16, maximum matrices per run.
- TOL, 32'h0000_0010, early-exit tolerance in Q16.16; used only with GSIM_EARLY_EXIT_EN.

Ports:
- i_clk, in, 1, clock, rising edge.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_module_en, in, 1, start pulse; sampled only in IDLE.
- i_matrix_num, in, 5, number of matrices to solve; values above MAX_MTX are clamped to MAX_MTX.
- o_proc_done, out, 1, one-cycle pulse when all matrices have been written.
- o_mem_rreq, out, 1, read request.
- o_mem_addr, out, MEM_AW, read address.
- i_mem_rrdy, in, 1, request accepted this cycle.
- i_mem_dout, in, N*AW, read data; element k is at bits [k*AW +: AW].
- i_mem_dout_vld, in, 1, read data valid; data returns in request order.
- o_x_wen, out, 1, result write enable.
- o_x_addr, out, 9, result address.
- o_x_data, out, XW, result data.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters, A/b/x arrays and the accumulator cleared. Reset asserted mid-run aborts immediately; no done pulse follows.
- Memory layout per matrix m (0-based): base = m*(N+1).
  - Word base holds b.
  - Word base+1+i holds row i of A.
  - The diagonal slot of row i holds r_i = round(2^15/a_ii), signed Q1.15, not a_ii.
- States: IDLE -> LOAD -> MAC -> UPD -> (MAC | WRITE) -> NEXT -> (LOAD | DONE) -> IDLE.
- IDLE:
  - i_module_en with clamped count 0 -> DONE; o_proc_done pulses the next cycle with no memory access.
  - i_module_en with clamped count > 0 -> LOAD with m = 0.
  - i_module_en in any other state is ignored.
- LOAD:
  - o_mem_rreq is high from the first LOAD cycle until N+1 requests have been accepted. A request is accepted on a cycle with o_mem_rreq & i_mem_rrdy.
  - o_mem_addr starts at base and increments only on acceptance. rreq and addr are registered and drop to 0 on the cycle after the last acceptance.
  - Returned words are counted on i_mem_dout_vld: word 0 -> b register, word k -> A row k-1.
  - Exit to MAC on the cycle after the (N+1)th valid word. x is cleared to 0 at LOAD entry.
- MAC, row i, column j = 0..N-1, one term per cycle:
  - Accumulator starts at b_i sign-extended and shifted left 16.
  - For j != i: acc -= a_ij * x_j. Use the current x_j, so rows updated earlier in the same sweep are already fresh (Gauss-Seidel).
  - For j == i: capture r_i; no accumulate.
  - Accumulator width is XW+AW+4 bits; it never saturates internally.
- UPD (1 cycle): x_i = saturate_XW((acc * r_i) >>> 15). Positive overflow -> 0x7FFF_FFFF; negative overflow -> 0x8000_0000.
  - Next row -> MAC.
  - After row N-1: increment the sweep counter; if it equals ITER -> WRITE, else MAC row 0.
- Cycle counts: N+1 cycles per row, N*(N+1)*ITER cycles per matrix excluding load.
- WRITE (N cycles): o_x_wen = 1, o_x_addr = m*N + i, o_x_data = x_i, for i = 0..N-1 on consecutive cycles. o_x_wen is 0 in all other states.
- NEXT: m += 1; m == clamped count -> DONE, else LOAD.
- DONE: o_proc_done = 1 for exactly one cycle -> IDLE.
- An i_mem_dout_vld outside LOAD is ignored. i_mem_rrdy while rreq is low is ignored.

Optional Feature:
- GSIM_EARLY_EXIT_EN defined:
  - During each sweep, track the maximum |x_i_new - x_i_old|.
  - At the end of a sweep, if that maximum <= TOL and at least 2 sweeps have run -> WRITE immediately.
  - Adds output o_early_exit (1 bit, reset 0), which is high during the WRITE state when the early exit was taken.
- Not defined: exactly ITER sweeps always run; no o_early_exit port and no comparator logic.

Test Plan:
- N=4, ITER=16, one matrix, A = 4·I (r = 0x2000), b = {4, 8, -4, 0}, rrdy always 1, vld 2 cycles later -> writes at addr 0..3: 0x0001_0000, 0x0002_0000, 0xFFFF_0000, 0x0000_0000; then o_proc_done pulses once.
- Same matrix with rrdy toggling 1-0-1-0 and vld gaps -> identical results; exactly 5 accepted requests at addresses 0..4.
- i_matrix_num = 3, N = 16, diagonally dominant set (a_ii = 20, off-diagonals ±1) -> 48 writes at addr 0..47; addresses 0, 17, 34 are the first requested addresses; results within 2 LSB of a golden model.
- i_matrix_num = 0 -> no rreq; o_proc_done high exactly 1 cycle after i_module_en. i_matrix_num = 20 -> 16 matrices solved.
- b = 0x7FFF, a_ii = 1 (r = 0x7FFF), off-diagonals -0x7FFF -> x clamps to 0x7FFF_FFFF, with no wrap.
- Reset pulsed low in the middle of MAC -> all outputs 0 next cycle, no done pulse; a new i_module_en restarts from address 0. With GSIM_EARLY_EXIT_EN and A = 4·I: o_early_exit = 1 after 2 sweeps, with the same results as the first scenario.
